// File: rtl/cordic_result_reader.sv
// cordic_result_reader: FIFO of DEPTH {x,y,z} result triples between the CORDIC core and its consumer.
// Latency: a push into an empty buffer is presented the cycle after the push edge (no flow-through).
// Backpressure: in_ready drops when the buffer is full, with no pop-bypass. A triple offered
//   while full is dropped and sets a sticky overflow flag, cleared only by reset.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready         producer handshake; in_x/in_y/in_z carry the result triple
//   out_valid/out_ready       consumer handshake; out_x/out_y/out_z show the oldest triple (zero when empty)
//   count                     number of buffered triples, 0..DEPTH
//   overflow                  sticky: a triple arrived while the buffer was full
module cordic_result_reader #(
  parameter int FIXED_POINT = 16,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [FIXED_POINT-1:0]     in_x,
  input  logic [FIXED_POINT-1:0]     in_y,
  input  logic [FIXED_POINT-1:0]     in_z,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIXED_POINT-1:0]     out_x,
  output logic [FIXED_POINT-1:0]     out_y,
  output logic [FIXED_POINT-1:0]     out_z,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage is deliberately not reset; empty-state output gating hides stale contents.
  logic [FIXED_POINT-1:0] r_mem_x [DEPTH];
  logic [FIXED_POINT-1:0] r_mem_y [DEPTH];
  logic [FIXED_POINT-1:0] r_mem_z [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // Status comes only from the registered count, so a full buffer does not
  // accept a push even when a pop happens on the same edge.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;
  assign w_drop  = in_valid & w_full;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

  assign out_x = w_empty ? '0 : r_mem_x[r_rptr];
  assign out_y = w_empty ? '0 : r_mem_y[r_rptr];
  assign out_z = w_empty ? '0 : r_mem_z[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wptr] <= in_x;
      r_mem_y[r_wptr] <= in_y;
      r_mem_z[r_wptr] <= in_z;
    end
  end

  // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 by natural rollover.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_result_reader.sv
// tb_cordic_result_reader: directed stimulus with hand-chosen triples; a negedge monitor
// keeps a queue of accepted triples and checks every presented output and status flag.
// Stimulus changes at posedge+2; the monitor samples at negedge.
module tb_cordic_result_reader;

  localparam int FP    = 16;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [FP-1:0] in_x, in_y, in_z;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [FP-1:0] out_x, out_y, out_z;
  logic [2:0]    count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  cordic_result_reader #(.FIXED_POINT(FP), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [47:0] sb[$];
  int          m_count = 0;
  logic        m_ovf   = 1'b0;

  always @(negedge clk) begin
    logic [47:0] exp_t;
    logic        do_push, do_pop;
    if (!rst) begin
      chk("mon_rst_in_ready",  {47'd0, in_ready},  48'd1);
      chk("mon_rst_out_valid", {47'd0, out_valid}, 48'd0);
      chk("mon_rst_count",     {45'd0, count},     48'd0);
      chk("mon_rst_overflow",  {47'd0, overflow},  48'd0);
      chk("mon_rst_out_xyz",   {out_x, out_y, out_z}, 48'd0);
      m_count = 0;
      m_ovf   = 1'b0;
      sb.delete();
    end else begin
      chk("mon_count",     {45'd0, count},     48'(m_count));
      chk("mon_in_ready",  {47'd0, in_ready},  {47'd0, (m_count != DEPTH)});
      chk("mon_out_valid", {47'd0, out_valid}, {47'd0, (m_count != 0)});
      chk("mon_overflow",  {47'd0, overflow},  {47'd0, m_ovf});
      if (m_count != 0) begin
        exp_t = sb[0];
        chk("mon_out_xyz", {out_x, out_y, out_z}, exp_t);
      end else begin
        chk("mon_idle_xyz_zero", {out_x, out_y, out_z}, 48'd0);
      end
      do_pop  = out_ready && (m_count != 0);
      do_push = in_valid && (m_count != DEPTH);
      if (in_valid && (m_count == DEPTH)) m_ovf = 1'b1;
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back({in_x, in_y, in_z});
      m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  // Applies inputs for one cycle; returns at posedge+2 with outputs reflecting that edge.
  task automatic drive(input logic iv, input logic [FP-1:0] x, input logic [FP-1:0] y,
                       input logic [FP-1:0] z, input logic ordy);
    in_valid  = iv;
    in_x      = x;
    in_y      = y;
    in_z      = z;
    out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_z = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_in_ready",  {47'd0, in_ready},  48'd1);
    chk("reset_out_valid", {47'd0, out_valid}, 48'd0);
    chk("reset_count",     {45'd0, count},     48'd0);
    chk("reset_out_x",     {32'd0, out_x},     48'd0);
    rst = 1'b1;

    // V-1: single push, visible the cycle after the push edge
    drive(1'b1, 16'h0010, 16'h0020, 16'h0030, 1'b0);
    chk("v1_out_valid", {47'd0, out_valid}, 48'd1);
    chk("v1_out_xyz",   {out_x, out_y, out_z}, 48'h0010_0020_0030);
    chk("v1_count",     {45'd0, count}, 48'd1);
    chk("v1_in_ready",  {47'd0, in_ready}, 48'd1);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("v1_drained", {45'd0, count}, 48'd0);

    // V-2: fill to DEPTH
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 16'(i), 16'(i + 16'h100), 16'(i + 16'h200), 1'b0);
    chk("v2_count_full", {45'd0, count}, 48'd4);
    chk("v2_in_ready",   {47'd0, in_ready}, 48'd0);

    // V-3: offer while full -> dropped, overflow set
    drive(1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    chk("v3_overflow", {47'd0, overflow}, 48'd1);
    chk("v3_count",    {45'd0, count}, 48'd4);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("v3_stall_stable", {out_x, out_y, out_z}, 48'h0001_0101_0201);

    // V-2 drain: 1,2,3,4 on consecutive cycles
    for (int i = 1; i <= 4; i++) begin
      chk("v2_pop_x", {32'd0, out_x}, 48'(i));
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    end
    chk("v2_empty_valid", {47'd0, out_valid}, 48'd0);
    chk("v2_empty_x",     {32'd0, out_x}, 48'd0);
    chk("v3_ovf_sticky",  {47'd0, overflow}, 48'd1);

    // V-6: out_ready on empty buffer has no effect
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
      chk("v6_count", {45'd0, count}, 48'd0);
    end

    // V-4: hold count=2 with simultaneous push/pop, pointers wrap several times
    drive(1'b1, 16'h0040, 16'h1040, 16'h2040, 1'b0);
    drive(1'b1, 16'h0041, 16'h1041, 16'h2041, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("v4_head_x", {32'd0, out_x}, 48'(16'h0040 + i));
      drive(1'b1, 16'(16'h0042 + i), 16'(16'h1042 + i), 16'(16'h2042 + i), 1'b1);
      chk("v4_count", {45'd0, count}, 48'd2);
    end
    chk("v4_tail_xyz", {out_x, out_y, out_z}, 48'h004A_104A_204A);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("v4_last_x", {32'd0, out_x}, 48'h004B);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);

    // V-5: asynchronous reset with three triples buffered
    for (int i = 0; i < 3; i++)
      drive(1'b1, 16'(16'h0050 + i), 16'h0, 16'h0, 1'b0);
    chk("v5_count3", {45'd0, count}, 48'd3);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("v5_async_valid", {47'd0, out_valid}, 48'd0);
    chk("v5_async_count", {45'd0, count}, 48'd0);
    chk("v5_async_ovf",   {47'd0, overflow}, 48'd0);
    chk("v5_async_x",     {32'd0, out_x}, 48'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive(1'b1, 16'h00AA, 16'h00BB, 16'h00CC, 1'b0);
    chk("v5_first_after_rst", {out_x, out_y, out_z}, 48'h00AA_00BB_00CC);
    chk("v5_count1", {45'd0, count}, 48'd1);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("v5_drained", {47'd0, out_valid}, 48'd0);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
